// File: rtl/pacman_map_pkg.sv
// Shared definitions for the maze map RAM and its access arbiter.
// Holds the coordinate and sprite widths, the sprite codes stored in the
// map, the internal counter widths, and the arbiter state type.
package pacman_map_pkg;

  localparam int MAP_W      = 5;
  localparam int DATA_W     = 3;
  localparam int WAIT_CNT_W = 4;  // holds MAX_WAIT up to 15
  localparam int LAT_CNT_W  = 2;  // holds READ_LATENCY-1 up to 2

  localparam logic [DATA_W-1:0] SPR_EMPTY  = 3'd0;
  localparam logic [DATA_W-1:0] SPR_WALL   = 3'd1;
  localparam logic [DATA_W-1:0] SPR_PELLET = 3'd2;
  localparam logic [DATA_W-1:0] SPR_POWER  = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } map_arb_state_t;

endpackage

// File: rtl/map_arb_pick.sv
// Combinational grant decision for the map access arbiter.
// Ports:
//   disp_req     display read request
//   game_req     game logic request
//   wait_cnt     display grants seen while game has been waiting
//   grant_valid  some requester is granted
//   grant_game   the grant goes to game logic (else display)
module map_arb_pick
  import pacman_map_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                  disp_req,
  input  logic                  game_req,
  input  logic [WAIT_CNT_W-1:0] wait_cnt,
  output logic                  grant_valid,
  output logic                  grant_game
);

  logic starved;

  // Display normally wins; once game has sat through MAX_WAIT display
  // grants it takes priority for one transaction.
  assign starved     = game_req && (wait_cnt == WAIT_CNT_W'(MAX_WAIT));
  assign grant_valid = disp_req || game_req;
  assign grant_game  = starved || (game_req && !disp_req);

endmodule

// File: rtl/map_access_arbiter.sv
// Single-port arbiter for the maze map RAM, shared between the display
// pipeline (reads) and game logic (reads and pellet writes). One
// transaction at a time: IDLE -> ISSUE -> WAIT (READ_LATENCY cycles) -> ACK.
// Ports:
//   clock_50, reset                   clock, async active-high reset
//   disp_req/x/y, disp_ack/rdata      display requester handshake
//   game_req/we/x/y/wdata, game_ack/rdata  game requester handshake
//   map_x/y, map_sprite_in, map_readwrite, map_sprite_out  map RAM side
//   busy                              not in IDLE
//   owner                             last granted requester (1 = game)
module map_access_arbiter #(
  parameter int MAP_W        = pacman_map_pkg::MAP_W,
  parameter int DATA_W       = pacman_map_pkg::DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [MAP_W-1:0]  disp_x,
  input  logic [MAP_W-1:0]  disp_y,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [MAP_W-1:0]  game_x,
  input  logic [MAP_W-1:0]  game_y,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  output logic [MAP_W-1:0]  map_x,
  output logic [MAP_W-1:0]  map_y,
  output logic [DATA_W-1:0] map_sprite_in,
  output logic              map_readwrite,
  input  logic [DATA_W-1:0] map_sprite_out,
  output logic              busy,
  output logic              owner
);

  import pacman_map_pkg::*;

  map_arb_state_t        state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [MAP_W-1:0]      map_x_q, map_x_d;
  logic [MAP_W-1:0]      map_y_q, map_y_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     disp_rdata_q, disp_rdata_d;
  logic [DATA_W-1:0]     game_rdata_q, game_rdata_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic                  grant_valid, grant_game;

  map_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .disp_req   (disp_req),
    .game_req   (game_req),
    .wait_cnt   (wait_cnt_q),
    .grant_valid(grant_valid),
    .grant_game (grant_game)
  );

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    map_x_d      = map_x_q;
    map_y_d      = map_y_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    disp_rdata_d = disp_rdata_q;
    game_rdata_d = game_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ISSUE;
          owner_d = grant_game;
          if (grant_game) begin
            map_x_d = game_x;
            map_y_d = game_y;
            wdata_d = game_wdata;
            we_d    = game_we;
          end else begin
            map_x_d = disp_x;
            map_y_d = disp_y;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = LAT_CNT_W'(READ_LATENCY - 1);
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ACK;
          // Writes leave the owner's read data untouched.
          if (!(owner_q && we_q)) begin
            if (owner_q) game_rdata_d = map_sprite_out;
            else         disp_rdata_d = map_sprite_out;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation count only moves on IDLE grants, and forgets everything
  // the moment game logic stops asking.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!game_req) begin
      wait_cnt_d = '0;
    end else if (state_q == IDLE && grant_valid) begin
      if (grant_game)
        wait_cnt_d = '0;
      else if (wait_cnt_q != WAIT_CNT_W'(MAX_WAIT))
        wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      map_x_q      <= '0;
      map_y_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      disp_rdata_q <= '0;
      game_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      map_x_q      <= map_x_d;
      map_y_q      <= map_y_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      disp_rdata_q <= disp_rdata_d;
      game_rdata_q <= game_rdata_d;
    end
  end

  // Decoded straight from state so reset silences them without a clock.
  assign map_readwrite = (state_q == ISSUE) && owner_q && we_q;
  assign busy          = (state_q != IDLE);
  assign disp_ack      = (state_q == ACK) && !owner_q;
  assign game_ack      = (state_q == ACK) && owner_q;

  assign map_x         = map_x_q;
  assign map_y         = map_y_q;
  assign map_sprite_in = wdata_q;
  assign owner         = owner_q;
  assign disp_rdata    = disp_rdata_q;
  assign game_rdata    = game_rdata_q;

endmodule

// File: tb/tb_map_access_arbiter.sv
module tb_map_access_arbiter;

  localparam int L  = 1;
  localparam int MW = 8;

  logic       clock_50 = 1'b0;
  logic       reset;
  logic       disp_req, game_req, game_we;
  logic [4:0] disp_x, disp_y, game_x, game_y;
  logic [2:0] game_wdata;
  logic       disp_ack, game_ack, map_readwrite, busy, owner;
  logic [2:0] disp_rdata, game_rdata, map_sprite_in, map_sprite_out;
  logic [4:0] map_x, map_y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock_50 = ~clock_50;

  map_access_arbiter #(.MAP_W(5), .DATA_W(3), .READ_LATENCY(L), .MAX_WAIT(MW)) dut (
    .clock_50      (clock_50),
    .reset         (reset),
    .disp_req      (disp_req),
    .disp_x        (disp_x),
    .disp_y        (disp_y),
    .disp_ack      (disp_ack),
    .disp_rdata    (disp_rdata),
    .game_req      (game_req),
    .game_we       (game_we),
    .game_x        (game_x),
    .game_y        (game_y),
    .game_wdata    (game_wdata),
    .game_ack      (game_ack),
    .game_rdata    (game_rdata),
    .map_x         (map_x),
    .map_y         (map_y),
    .map_sprite_in (map_sprite_in),
    .map_readwrite (map_readwrite),
    .map_sprite_out(map_sprite_out),
    .busy          (busy),
    .owner         (owner)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat(int x, int y);
    return 3'(x + y + 3);
  endfunction

  // Map RAM: samples address on each edge, data appears L cycles later.
  logic [2:0] ram_mem [0:31][0:31];
  logic [2:0] rd_pipe [0:L-1];

  always @(posedge clock_50) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++) ram_mem[i][j] <= pat(i, j);
    end else if (map_readwrite) begin
      ram_mem[map_x][map_y] <= map_sprite_in;
    end
    rd_pipe[0] <= ram_mem[map_x][map_y];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign map_sprite_out = rd_pipe[L-1];

  // Transaction-level reference: a grant at IDLE cycle c gives ISSUE at
  // c+1, ack at c+2+L; read data appears with the ack.
  logic [2:0] exp_mem [0:31][0:31];
  int   cyc = 0, t_issue = 0, wc = 0, n_txn = 0;
  bit   m_act, m_game, m_we, was_idle, g_any, g_game;
  bit   disp_inflight, game_inflight;
  logic [4:0] e_mx, e_my;
  logic [2:0] e_spr, e_drd, e_grd;
  bit   e_owner;

  always @(negedge clock_50) begin
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_acks", {disp_ack, game_ack}, 0);
      chk("rst_rw", map_readwrite, 0);
      chk("rst_owner", owner, 0);
      chk("rst_map_xy", {map_x, map_y}, 0);
      chk("rst_spr_in", map_sprite_in, 0);
      chk("rst_rdata", {disp_rdata, game_rdata}, 0);
      m_act = 0; wc = 0; disp_inflight = 0; game_inflight = 0;
      e_mx = 0; e_my = 0; e_spr = 0; e_drd = 0; e_grd = 0; e_owner = 0;
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++) exp_mem[i][j] = pat(i, j);
    end else begin
      chk("busy", busy, m_act);
      chk("map_readwrite", map_readwrite, m_act && cyc == t_issue && m_game && m_we);
      chk("disp_ack", disp_ack, m_act && cyc == t_issue + 1 + L && !m_game);
      chk("game_ack", game_ack, m_act && cyc == t_issue + 1 + L && m_game);
      chk("owner", owner, e_owner);
      chk("map_xy", {map_x, map_y}, {e_mx, e_my});
      chk("map_sprite_in", map_sprite_in, e_spr);
      chk("disp_rdata", disp_rdata, e_drd);
      chk("game_rdata", game_rdata, e_grd);

      was_idle = !m_act;
      if (m_act && cyc == t_issue + L && !(m_game && m_we)) begin
        if (m_game) e_grd = exp_mem[e_mx][e_my];
        else        e_drd = exp_mem[e_mx][e_my];
      end
      if (m_act && cyc == t_issue + 1 + L) begin
        m_act = 0;
        n_txn++;
        if (m_game) game_inflight = 0; else disp_inflight = 0;
      end

      g_any  = disp_req || game_req;
      g_game = game_req && (wc == MW || !disp_req);
      if (was_idle && g_any) begin
        m_act = 1; t_issue = cyc + 1; m_game = g_game; e_owner = g_game;
        if (g_game) begin
          e_mx = game_x; e_my = game_y; m_we = game_we; e_spr = game_wdata;
          if (game_we) exp_mem[game_x][game_y] = game_wdata;
          game_inflight = 1;
        end else begin
          e_mx = disp_x; e_my = disp_y;
          disp_inflight = 1;
        end
      end

      if (!game_req) wc = 0;
      else if (was_idle && g_any) begin
        if (g_game) wc = 0;
        else if (wc < MW) wc++;
      end
      cyc++;
    end
  end

  task automatic run_txn(input bit g, input bit we, input logic [4:0] x, input logic [4:0] y,
                         input logic [2:0] wd, output int ack_at, output logic [2:0] rd,
                         output logic [7:0] rw_tr, output logic [9:0] xy1);
    @(posedge clock_50); #1;
    if (g) begin
      game_req = 1; game_we = we; game_x = x; game_y = y; game_wdata = wd;
    end else begin
      disp_req = 1; disp_x = x; disp_y = y;
    end
    ack_at = -1; rd = 0; rw_tr = 0; xy1 = 0;
    for (int k = 0; k < 8 + 2 * L; k++) begin
      @(negedge clock_50);
      if (k < 8) rw_tr[k] = map_readwrite;
      if (k == 1) xy1 = {map_x, map_y};
      if (g ? game_ack : disp_ack) begin
        ack_at = k;
        rd = g ? game_rdata : disp_rdata;
        break;
      end
    end
    @(posedge clock_50); #1;
    if (g) game_req = 0; else disp_req = 0;
  endtask

  initial begin
    int         ack_at, first_game;
    logic [2:0] rd;
    logic [7:0] rw_tr;
    logic [9:0] xy1;
    bit         seq[$];

    reset = 1; disp_req = 0; game_req = 0; game_we = 0;
    disp_x = 0; disp_y = 0; game_x = 0; game_y = 0; game_wdata = 0;
    repeat (3) @(posedge clock_50);
    #1 reset = 0;
    repeat (2) @(posedge clock_50);

    // Single display read of (3,4): RAM holds 3+4+3 = 10 -> 3'b010.
    run_txn(0, 0, 5'd3, 5'd4, 3'd0, ack_at, rd, rw_tr, xy1);
    chk("dread_ack_cycle", ack_at, 2 + L);
    chk("dread_rdata", rd, 3'b010);
    chk("dread_map_xy_t1", xy1, {5'd3, 5'd4});
    chk("dread_rw_never", rw_tr, 8'h00);

    // Game read of (7,2) = 12 -> 4, then write 0, then read back 0.
    run_txn(1, 0, 5'd7, 5'd2, 3'd5, ack_at, rd, rw_tr, xy1);
    chk("gread_pre_rdata", rd, 3'd4);
    chk("gread_pre_rw", rw_tr, 8'h00);
    run_txn(1, 1, 5'd7, 5'd2, 3'b000, ack_at, rd, rw_tr, xy1);
    chk("gwrite_ack_cycle", ack_at, 2 + L);
    chk("gwrite_rw_only_t1", rw_tr, 8'b0000_0010);
    chk("gwrite_rdata_kept", rd, 3'd4);
    run_txn(1, 0, 5'd7, 5'd2, 3'd6, ack_at, rd, rw_tr, xy1);
    chk("gread_post_rdata", rd, 3'b000);

    // Contention: both held, MW display grants then one game grant.
    @(posedge clock_50); #1;
    disp_req = 1; game_req = 1; game_we = 0;
    for (int k = 0; k < 12 * (L + 3) + 5 && seq.size() < 10; k++) begin
      @(negedge clock_50);
      if (disp_ack) seq.push_back(1'b0);
      if (game_ack) seq.push_back(1'b1);
    end
    first_game = -1;
    foreach (seq[i]) if (seq[i] && first_game < 0) first_game = i;
    chk("contend_disp_before_game", first_game, MW);
    chk("contend_after_game_disp", (seq.size() >= 10) ? {31'd0, seq[9]} : 32'd1, 0);
    @(posedge clock_50); #1;
    disp_req = 0; game_req = 0;
    repeat (L + 5) @(posedge clock_50);

    // Reset during WAIT of a game read.
    #1 game_req = 1; game_we = 0; game_x = 3; game_y = 4;
    repeat (2) @(posedge clock_50);
    #2 reset = 1; game_req = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_acks", {disp_ack, game_ack}, 0);
    chk("async_rst_rw", map_readwrite, 0);
    repeat (2) @(posedge clock_50);
    #1 reset = 0;
    run_txn(0, 0, 5'd3, 5'd4, 3'd0, ack_at, rd, rw_tr, xy1);
    chk("post_rst_ack_cycle", ack_at, 2 + L);
    chk("post_rst_rdata", rd, 3'b010);

    // Randomized traffic checked by the reference every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock_50); #1;
      disp_x = 5'($urandom_range(0, 3)); disp_y = 5'($urandom_range(0, 3));
      game_x = 5'($urandom_range(0, 3)); game_y = 5'($urandom_range(0, 3));
      game_wdata = 3'($urandom_range(0, 7));
      game_we = 1'($urandom_range(0, 1));
      if (!disp_req) disp_req = ($urandom_range(0, 2) == 0);
      else if (!disp_inflight && $urandom_range(0, 7) == 0) disp_req = 0;
      if (!game_req) game_req = ($urandom_range(0, 3) == 0);
      else if (!game_inflight && $urandom_range(0, 7) == 0) game_req = 0;
    end
    @(posedge clock_50); #1;
    disp_req = 0; game_req = 0;
    repeat (L + 5) @(posedge clock_50);
    chk("random_activity", n_txn > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/map_access_arbiter.md
# map_access_arbiter

Single-port arbiter for the maze map RAM (`MapController`). It shares that RAM between two requesters:
- the display pipeline (`DisplayController`), read-only, high rate;
- the game logic (Pacman/ghost controllers), reads for collision lookups and writes for eaten pellets.

It sits between `MainModule` and `MapController`, owns the map address, data and readwrite lines, and runs one transaction at a time with a req/ack handshake and a starvation guard for game logic.

## Interface
Parameters:
- `MAP_W`, 5, map x/y coordinate width
- `DATA_W`, 3, sprite code width
- `READ_LATENCY`, 1, map RAM cycles from address sample to valid `map_sprite_out` (legal 1..3)
- `MAX_WAIT`, 8, display grants tolerated while game request pending (legal 1..15)

Ports (clock and reset first):
- `clock_50`  in  1  system clock; all state on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `disp_req`  in  1  display read request; held until `disp_ack`
- `disp_x`, `disp_y`  in  MAP_W  display read coordinate
- `disp_ack`  out  1  one-cycle completion pulse
- `disp_rdata`  out  DATA_W  read result; valid with `disp_ack`, held until next display read
- `game_req`  in  1  game request; held until `game_ack`
- `game_we`  in  1  1 = write, 0 = read
- `game_x`, `game_y`  in  MAP_W  game coordinate
- `game_wdata`  in  DATA_W  write sprite code
- `game_ack`  out  1  one-cycle completion pulse
- `game_rdata`  out  DATA_W  read result; updated on game reads only
- `map_x`, `map_y`  out  MAP_W  to `MapController`
- `map_sprite_in`  out  DATA_W  write data to map
- `map_readwrite`  out  1  0 read, 1 write
- `map_sprite_out`  in  DATA_W  map read data
- `busy`  out  1  high in any state other than IDLE
- `owner`  out  1  0 display, 1 game; last granted requester

## Operation
States and transitions:
- IDLE: sample requests and arbitrate; on any grant go to ISSUE; otherwise stay.
- ISSUE: one cycle; go to WAIT.
- WAIT: exactly READ_LATENCY cycles; go to ACK.
- ACK: one cycle; go to IDLE.

Arbitration, evaluated in IDLE only:
1. If `game_req` and `wait_cnt == MAX_WAIT`, grant game.
2. Else if `disp_req`, grant display.
3. Else if `game_req`, grant game.

Starvation counter `wait_cnt`:
- Increments on each display grant while `game_req` is high.
- Saturates at MAX_WAIT.
- Clears on a game grant, or in any cycle `game_req` is low.

On grant, registered into map outputs and held stable from ISSUE through ACK and on into IDLE:
- the granted requester's x/y;
- for game, `game_wdata` into `map_sprite_in` and `game_we`.

`map_readwrite` is high only during ISSUE of a game write; it is 0 in every other state.

At the last WAIT cycle edge:
- Read: `map_sprite_out` is captured into the owner's rdata.
- Write: rdata is unchanged.

The owner's ack is high for the whole ACK cycle; the other ack stays 0.

Requests are not sampled in ISSUE, WAIT or ACK. A requester still holding req after its ack gets a new transaction through IDLE arbitration.

Requester inputs are sampled only at grant. Changes after grant are ignored.

## Timing
Reset values:
- state IDLE, `wait_cnt` 0;
- all outputs 0: acks, rdata, map_x/y, `map_sprite_in`, `map_readwrite`, `busy`, `owner`.

Latency and throughput:
- Req high in IDLE cycle t: ISSUE at t+1, WAIT t+2..t+1+L, ack during cycle t+2+L (L = READ_LATENCY).
- Throughput: one transaction per L+3 cycles.

Boundary conditions:
- Both requests in the same IDLE cycle: display wins unless `wait_cnt == MAX_WAIT`.
- With display permanently requesting, game is granted after exactly MAX_WAIT display transactions.
- Requester drops req before grant: no transaction, no ack.
- Reset asserted mid-transaction:
  - state → IDLE and all outputs → 0 immediately (asynchronous);
  - any in-flight ack is lost;
  - a write already in ISSUE may have been sampled by the RAM; no write occurs after reset assertion.

## Structure
- Shared package `pacman_map_pkg` holds `MAP_W`, `DATA_W`, the sprite code constants (empty, wall, pellet, power pellet), and the `map_arb_state_t` enum {IDLE, ISSUE, WAIT, ACK}.
- One natural sub-module: `map_arb_pick`, the combinational grant decision (inputs `disp_req`, `game_req`, `wait_cnt`; outputs `grant_valid`, `grant_game`).
- Latency counter and starvation counter live in the top.

## Test plan
- Single display read, L=1: `disp_req` at t with (3,4), RAM holds 3'b010 → `map_x`=3, `map_y`=4 at t+1, `disp_ack`=1 and `disp_rdata`=3'b010 at t+3, `map_readwrite` 0 throughout.
- Game write: `game_we`=1, (7,2), wdata 3'b000 → `map_readwrite`=1 only at t+1, `game_ack` at t+3, then a game read of (7,2) returns 3'b000 and `game_rdata`=3'b000.
- Contention with MAX_WAIT=8, both reqs held: eight consecutive `disp_ack`s, then `game_ack` on the 9th transaction; `wait_cnt` returns to 0.
- READ_LATENCY=3 build: single read → ack at t+5; `disp_rdata` equals RAM content at the addressed cell.
- Reset during WAIT of a game read → `busy`, acks and `map_readwrite` 0 in the same cycle; after release, first request completes normally at t+2+L.
